// File: rtl/cdb_arbiter_if.sv
// ---------------------------------------------------------------------------
// cdb_arbiter_if
// Bundles the functional-unit request side and the common data bus
// broadcast side of the CDB arbiter.
//
// Request side (driven by the functional units):
//    req_valid, req_tag, req_zeroreg, req_value, req_npc, req_take_branch
//    req_ready (returned by the arbiter, one-hot grant)
// Broadcast side (driven by the arbiter):
//    cdb_valid, cdb_tag_valid, cdb_tag, cdb_value, cdb_npc,
//    cdb_take_branch, cdb_src
//
// Modports:
//    slave  - the arbiter
//    master - the functional units / broadcast consumers
// ---------------------------------------------------------------------------
interface cdb_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int TAG_W   = 6,
   parameter int XLEN    = 32
);

   localparam int SRC_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [NUM_REQ-1:0]            req_valid;
   logic [NUM_REQ-1:0][TAG_W-1:0] req_tag;
   logic [NUM_REQ-1:0]            req_zeroreg;
   logic [NUM_REQ-1:0][XLEN-1:0]  req_value;
   logic [NUM_REQ-1:0][XLEN-1:0]  req_npc;
   logic [NUM_REQ-1:0]            req_take_branch;
   logic [NUM_REQ-1:0]            req_ready;

   logic                          cdb_valid;
   logic                          cdb_tag_valid;
   logic [TAG_W-1:0]              cdb_tag;
   logic [XLEN-1:0]               cdb_value;
   logic [XLEN-1:0]               cdb_npc;
   logic                          cdb_take_branch;
   logic [SRC_W-1:0]              cdb_src;

   modport slave (
      input  req_valid, req_tag, req_zeroreg, req_value, req_npc, req_take_branch,
      output req_ready,
      output cdb_valid, cdb_tag_valid, cdb_tag, cdb_value, cdb_npc,
             cdb_take_branch, cdb_src
   );

   modport master (
      output req_valid, req_tag, req_zeroreg, req_value, req_npc, req_take_branch,
      input  req_ready,
      input  cdb_valid, cdb_tag_valid, cdb_tag, cdb_value, cdb_npc,
             cdb_take_branch, cdb_src
   );

endinterface

// File: rtl/cdb_arbiter.sv
// ---------------------------------------------------------------------------
// cdb_arbiter
// Round-robin arbiter granting one functional unit per cycle access to the
// common data bus. The winner's result is registered and broadcast for
// exactly one cycle, the cycle after the transfer.
//
// Ports:
//    clock   - sole clock, rising edge
//    reset   - synchronous active-high reset
//    squash  - branch-mispredict flush, blocks any grant this cycle
//    bus     - cdb_arbiter_if.slave: FU requests in, one-hot req_ready and
//              registered cdb_* broadcast out
// ---------------------------------------------------------------------------
module cdb_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int TAG_W   = 6,
   parameter int XLEN    = 32
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          squash,
   cdb_arbiter_if.slave  bus
);

   localparam int SRC_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [SRC_W-1:0] LAST_IDX = SRC_W'(NUM_REQ - 1);

   logic [SRC_W-1:0]   rrPtr_q, rrPtr_d;
   logic [SRC_W-1:0]   grantIdx;
   logic [SRC_W-1:0]   probeIdx;
   logic               grantFound;
   logic               transfer;
   logic [NUM_REQ-1:0] grantOneHot;

   logic               cdbValid_q, cdbValid_d;
   logic               cdbTagValid_q, cdbTagValid_d;
   logic [TAG_W-1:0]   cdbTag_q, cdbTag_d;
   logic [XLEN-1:0]    cdbValue_q, cdbValue_d;
   logic [XLEN-1:0]    cdbNpc_q, cdbNpc_d;
   logic               cdbTakeBranch_q, cdbTakeBranch_d;
   logic [SRC_W-1:0]   cdbSrc_q, cdbSrc_d;

   // Round-robin search: walk the requesters starting at rrPtr_q, wrapping
   // past the last index, and take the first one with a pending request.
   always_comb begin
      grantFound = 1'b0;
      grantIdx   = '0;
      probeIdx   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         probeIdx = SRC_W'((int'(rrPtr_q) + k) % NUM_REQ);
         if (!grantFound && bus.req_valid[probeIdx]) begin
            grantFound = 1'b1;
            grantIdx   = probeIdx;
         end
      end
   end

   // A grant only becomes a transfer when neither reset nor squash is
   // holding the bus; req_ready is derived from that so it stays all-zero
   // in those cycles and the FUs keep holding their requests.
   always_comb begin
      transfer    = grantFound & ~reset & ~squash;
      grantOneHot = '0;
      if (transfer) begin
         grantOneHot[grantIdx] = 1'b1;
      end
   end

   // Next-state for the pointer and the broadcast slot. The broadcast
   // payload fields only load on a transfer and otherwise keep their old
   // value; only the valid flags drop. A taken branch reports its target,
   // which the FU supplies on req_value, as the next PC.
   always_comb begin
      rrPtr_d         = rrPtr_q;
      cdbValid_d      = transfer;
      cdbTagValid_d   = 1'b0;
      cdbTag_d        = cdbTag_q;
      cdbValue_d      = cdbValue_q;
      cdbNpc_d        = cdbNpc_q;
      cdbTakeBranch_d = cdbTakeBranch_q;
      cdbSrc_d        = cdbSrc_q;
      if (transfer) begin
         rrPtr_d         = (grantIdx == LAST_IDX) ? '0 : grantIdx + 1'b1;
         cdbTagValid_d   = ~bus.req_zeroreg[grantIdx];
         cdbTag_d        = bus.req_tag[grantIdx];
         cdbValue_d      = bus.req_value[grantIdx];
         cdbNpc_d        = bus.req_take_branch[grantIdx] ? bus.req_value[grantIdx]
                                                         : bus.req_npc[grantIdx];
         cdbTakeBranch_d = bus.req_take_branch[grantIdx];
         cdbSrc_d        = grantIdx;
      end
   end

   // State registers; reset clears the pointer and the whole broadcast slot
   // so arbitration restarts from requester 0.
   always_ff @(posedge clock) begin
      if (reset) begin
         rrPtr_q         <= '0;
         cdbValid_q      <= 1'b0;
         cdbTagValid_q   <= 1'b0;
         cdbTag_q        <= '0;
         cdbValue_q      <= '0;
         cdbNpc_q        <= '0;
         cdbTakeBranch_q <= 1'b0;
         cdbSrc_q        <= '0;
      end else begin
         rrPtr_q         <= rrPtr_d;
         cdbValid_q      <= cdbValid_d;
         cdbTagValid_q   <= cdbTagValid_d;
         cdbTag_q        <= cdbTag_d;
         cdbValue_q      <= cdbValue_d;
         cdbNpc_q        <= cdbNpc_d;
         cdbTakeBranch_q <= cdbTakeBranch_d;
         cdbSrc_q        <= cdbSrc_d;
      end
   end

   assign bus.req_ready       = grantOneHot;
   assign bus.cdb_valid       = cdbValid_q;
   assign bus.cdb_tag_valid   = cdbTagValid_q;
   assign bus.cdb_tag         = cdbTag_q;
   assign bus.cdb_value       = cdbValue_q;
   assign bus.cdb_npc         = cdbNpc_q;
   assign bus.cdb_take_branch = cdbTakeBranch_q;
   assign bus.cdb_src         = cdbSrc_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cdb_arbiter
// Directed testbench for cdb_arbiter with hand-computed expected values.
// Inputs change on the falling edge; req_ready is sampled 1ns later and the
// registered broadcast 1ns after each rising edge.
// ---------------------------------------------------------------------------
module tb_cdb_arbiter;

   logic clock;
   logic reset;
   logic squash;
   int   assertCount;
   int   failCount;

   cdb_arbiter_if #(.NUM_REQ(4), .TAG_W(6), .XLEN(32)) bus ();

   cdb_arbiter #(.NUM_REQ(4), .TAG_W(6), .XLEN(32)) dut (
      .clock  (clock),
      .reset  (reset),
      .squash (squash),
      .bus    (bus)
   );

   // Free-running clock, 10ns period.
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Compare one observed value against its expected value.
   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      assertCount++;
      assert (observed === expected)
      else begin
         failCount++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Load the payload fields of one requester.
   task automatic setReq(input int idx, input logic [5:0] tag, input logic zr,
                         input logic [31:0] value, input logic [31:0] npc,
                         input logic tb);
      bus.req_tag[idx]         = tag;
      bus.req_zeroreg[idx]     = zr;
      bus.req_value[idx]       = value;
      bus.req_npc[idx]         = npc;
      bus.req_take_branch[idx] = tb;
   endtask

   // Drive control inputs on the falling edge, then let combinational logic settle.
   task automatic applyStimulus(input logic rst, input logic sq, input logic [3:0] valid);
      @(negedge clock);
      reset         = rst;
      squash        = sq;
      bus.req_valid = valid;
      #1;
   endtask

   // Advance past the next rising edge.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Directed sequence; rr pointer value noted after each transfer.
   initial begin
      logic [1:0] grantSeq [5];
      assertCount = 0;
      failCount   = 0;
      reset       = 1'b1;
      squash      = 1'b0;
      bus.req_valid = '0;
      for (int i = 0; i < 4; i++) begin
         setReq(i, 6'(i + 1), 1'b0, 32'(i + 100), 32'(i + 200), 1'b0);
      end

      // Reset with requests pending: no grants, broadcast slot cleared.
      applyStimulus(1'b1, 1'b0, 4'b1111);
      checkOutput("reset_ready", 64'(bus.req_ready), 64'h0);
      tick();
      tick();
      checkOutput("reset_valid", 64'(bus.cdb_valid), 64'h0);
      checkOutput("reset_tagvalid", 64'(bus.cdb_tag_valid), 64'h0);
      checkOutput("reset_tag", 64'(bus.cdb_tag), 64'h0);
      checkOutput("reset_value", 64'(bus.cdb_value), 64'h0);
      checkOutput("reset_npc", 64'(bus.cdb_npc), 64'h0);
      checkOutput("reset_takebr", 64'(bus.cdb_take_branch), 64'h0);
      checkOutput("reset_src", 64'(bus.cdb_src), 64'h0);

      // Single request from FU1, tag 5, value 0xAB. rr -> 2.
      setReq(1, 6'd5, 1'b0, 32'hAB, 32'h4, 1'b0);
      applyStimulus(1'b0, 1'b0, 4'b0010);
      checkOutput("single_ready", 64'(bus.req_ready), 64'h2);
      tick();
      checkOutput("single_valid", 64'(bus.cdb_valid), 64'h1);
      checkOutput("single_tagvalid", 64'(bus.cdb_tag_valid), 64'h1);
      checkOutput("single_tag", 64'(bus.cdb_tag), 64'h5);
      checkOutput("single_value", 64'(bus.cdb_value), 64'hAB);
      checkOutput("single_npc", 64'(bus.cdb_npc), 64'h4);
      checkOutput("single_src", 64'(bus.cdb_src), 64'h1);

      // Idle cycle: valid drops, payload holds.
      applyStimulus(1'b0, 1'b0, 4'b0000);
      checkOutput("idle_ready", 64'(bus.req_ready), 64'h0);
      tick();
      checkOutput("idle_valid", 64'(bus.cdb_valid), 64'h0);
      checkOutput("idle_tagvalid", 64'(bus.cdb_tag_valid), 64'h0);
      checkOutput("idle_tag_hold", 64'(bus.cdb_tag), 64'h5);

      // Taken branch from FU2: npc is the value. rr -> 3.
      setReq(2, 6'd7, 1'b0, 32'h1000, 32'h44, 1'b1);
      applyStimulus(1'b0, 1'b0, 4'b0100);
      checkOutput("brtaken_ready", 64'(bus.req_ready), 64'h4);
      tick();
      checkOutput("brtaken_npc", 64'(bus.cdb_npc), 64'h1000);
      checkOutput("brtaken_takebr", 64'(bus.cdb_take_branch), 64'h1);
      checkOutput("brtaken_src", 64'(bus.cdb_src), 64'h2);

      // Not-taken branch from FU3: npc is req_npc. rr -> 0.
      setReq(3, 6'd9, 1'b0, 32'h1000, 32'h44, 1'b0);
      applyStimulus(1'b0, 1'b0, 4'b1000);
      checkOutput("brnot_ready", 64'(bus.req_ready), 64'h8);
      tick();
      checkOutput("brnot_npc", 64'(bus.cdb_npc), 64'h44);
      checkOutput("brnot_takebr", 64'(bus.cdb_take_branch), 64'h0);
      checkOutput("brnot_src", 64'(bus.cdb_src), 64'h3);

      // Zero-register completion from FU0. rr -> 1.
      setReq(0, 6'd0, 1'b1, 32'h55, 32'h8, 1'b0);
      applyStimulus(1'b0, 1'b0, 4'b0001);
      checkOutput("zero_ready", 64'(bus.req_ready), 64'h1);
      tick();
      checkOutput("zero_valid", 64'(bus.cdb_valid), 64'h1);
      checkOutput("zero_tagvalid", 64'(bus.cdb_tag_valid), 64'h0);
      checkOutput("zero_src", 64'(bus.cdb_src), 64'h0);

      // FU1 and FU2 pending, rr=1 -> FU1 wins. rr -> 2.
      applyStimulus(1'b0, 1'b0, 4'b0110);
      checkOutput("rr1_ready", 64'(bus.req_ready), 64'h2);
      tick();
      checkOutput("rr1_src", 64'(bus.cdb_src), 64'h1);

      // Squash with all pending at rr=2: no grant, prior broadcast visible.
      applyStimulus(1'b0, 1'b1, 4'b1111);
      checkOutput("squash_ready", 64'(bus.req_ready), 64'h0);
      checkOutput("squash_prev_valid", 64'(bus.cdb_valid), 64'h1);
      checkOutput("squash_prev_src", 64'(bus.cdb_src), 64'h1);
      tick();
      checkOutput("squash_next_valid", 64'(bus.cdb_valid), 64'h0);

      // After squash the pointer still sits at 2. rr -> 3.
      applyStimulus(1'b0, 1'b0, 4'b1111);
      checkOutput("postsq_ready", 64'(bus.req_ready), 64'h4);
      tick();
      checkOutput("postsq_src", 64'(bus.cdb_src), 64'h2);
      checkOutput("postsq_tag", 64'(bus.cdb_tag), 64'h7);

      // Reset mid-stream with rr=3 and FU1/FU3 pending.
      applyStimulus(1'b1, 1'b0, 4'b1010);
      checkOutput("midrst_ready", 64'(bus.req_ready), 64'h0);
      tick();
      checkOutput("midrst_valid", 64'(bus.cdb_valid), 64'h0);
      checkOutput("midrst_tag", 64'(bus.cdb_tag), 64'h0);
      checkOutput("midrst_value", 64'(bus.cdb_value), 64'h0);
      checkOutput("midrst_npc", 64'(bus.cdb_npc), 64'h0);
      checkOutput("midrst_src", 64'(bus.cdb_src), 64'h0);

      // Release: lowest valid index (1) wins, not 3.
      applyStimulus(1'b0, 1'b0, 4'b1010);
      checkOutput("release_ready", 64'(bus.req_ready), 64'h2);
      tick();
      checkOutput("release_src", 64'(bus.cdb_src), 64'h1);

      // All four held from reset: grants 0,1,2,3,0 back to back.
      for (int i = 0; i < 4; i++) begin
         setReq(i, 6'(i + 10), 1'b0, 32'(i + 300), 32'(i + 400), 1'b0);
      end
      applyStimulus(1'b1, 1'b0, 4'b1111);
      tick();
      applyStimulus(1'b0, 1'b0, 4'b1111);
      grantSeq[0] = 2'd0;
      grantSeq[1] = 2'd1;
      grantSeq[2] = 2'd2;
      grantSeq[3] = 2'd3;
      grantSeq[4] = 2'd0;
      for (int n = 0; n < 5; n++) begin
         checkOutput($sformatf("rr_ready_%0d", n), 64'(bus.req_ready),
                     64'(4'b0001 << grantSeq[n]));
         tick();
         checkOutput($sformatf("rr_valid_%0d", n), 64'(bus.cdb_valid), 64'h1);
         checkOutput($sformatf("rr_src_%0d", n), 64'(bus.cdb_src), 64'(grantSeq[n]));
         checkOutput($sformatf("rr_tag_%0d", n), 64'(bus.cdb_tag), 64'(grantSeq[n]) + 64'd10);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
